// File: rtl/demux_pkg.sv
// -----------------------------------------------------------------------------
// demux_pkg
// Shared definitions for the demux select sequencer:
//   NUM_CH      - number of demux outputs (power of two, >= 2)
//   SEL_W       - select width, $clog2(NUM_CH)
//   seq_state_t - sequencer FSM states (IDLE, SCAN, DONE)
//   next_ch_t   - result of a channel search (found flag + index)
//   next_set_bit(mask, idx, from_start) - lowest set bit of mask above idx,
//                 or the lowest set bit overall when from_start is high
// -----------------------------------------------------------------------------
package demux_pkg;

  localparam int NUM_CH = 8;
  localparam int SEL_W  = $clog2(NUM_CH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } seq_state_t;

  typedef struct packed {
    logic             found;
    logic [SEL_W-1:0] idx;
  } next_ch_t;

  // Walk from the top bit down so that the last hit recorded is the lowest
  // qualifying index. from_start behaves like a search that begins at -1,
  // which is how the first channel of a sweep is located.
  function automatic next_ch_t next_set_bit(input logic [NUM_CH-1:0] mask,
                                            input logic [SEL_W-1:0]  idx,
                                            input logic              from_start);
    next_ch_t r;
    r.found = 1'b0;
    r.idx   = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      if (mask[k] && (from_start || (k > int'(idx)))) begin
        r.found = 1'b1;
        r.idx   = SEL_W'(k);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/demux_next_ch.sv
// -----------------------------------------------------------------------------
// demux_next_ch
// Combinational priority finder: returns the lowest enabled channel strictly
// above cur_idx, or the lowest enabled channel overall when from_start is set.
// Ports:
//   mask       in  NUM_CH  channel enable bitmap to search
//   cur_idx    in  SEL_W   current channel index
//   from_start in  1       search from -1 (ignore cur_idx)
//   found      out 1       a qualifying channel exists
//   next_idx   out SEL_W   index of that channel (0 when not found)
// -----------------------------------------------------------------------------
module demux_next_ch
  import demux_pkg::*;
(
  input  logic [NUM_CH-1:0] mask,
  input  logic [SEL_W-1:0]  cur_idx,
  input  logic              from_start,
  output logic              found,
  output logic [SEL_W-1:0]  next_idx
);

  next_ch_t res;

  assign res      = next_set_bit(mask, cur_idx, from_start);
  assign found    = res.found;
  assign next_idx = res.idx;

endmodule

// File: rtl/demux_sel_sequencer.sv
// -----------------------------------------------------------------------------
// demux_sel_sequencer
// Upstream driver for an NUM_CH-way 1:N demux. On an accepted start it scans
// the enabled channels in ascending order, holds each for dwell cycles and
// gates din onto the selected channel. busy/done let a controller chain
// sweeps.
// Optional feature macro: DEMUX_SEQ_LOOP_EN
//   When defined, the sweep wraps to the lowest enabled channel instead of
//   finishing, pulsing done at every wrap, until stop is seen; stop lets the
//   current channel finish its dwell before entering DONE.
// Ports:
//   clk      in  1        system clock, rising edge
//   rst      in  1        synchronous active-high reset
//   start    in  1        sweep request, honoured only in IDLE
//   dwell    in  DWELL_W  cycles per channel (0 treated as 1), latched on start
//   ch_mask  in  NUM_CH   channel enable bitmap, latched on start
//   din      in  1        serial data to route
//   stop     in  1        end looping sweep (only with DEMUX_SEQ_LOOP_EN)
//   sel_o    out SEL_W    demux select, registered
//   dout     out 1        din gated by ch_valid
//   ch_valid out 1        sel_o points at a channel being dwelt on
//   busy     out 1        sweep in progress
//   done     out 1        one-cycle end-of-sweep (or wrap) pulse
// -----------------------------------------------------------------------------
module demux_sel_sequencer
  import demux_pkg::*;
#(
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [DWELL_W-1:0] dwell,
  input  logic [NUM_CH-1:0]  ch_mask,
  input  logic               din,
`ifdef DEMUX_SEQ_LOOP_EN
  input  logic               stop,
`endif
  output logic [SEL_W-1:0]   sel_o,
  output logic               dout,
  output logic               ch_valid,
  output logic               busy,
  output logic               done
);

  seq_state_t         state_q,    state_d;
  logic [SEL_W-1:0]   sel_q,      sel_d;
  logic               ch_valid_q, ch_valid_d;
  logic               busy_q,     busy_d;
  logic               done_q,     done_d;
  logic [DWELL_W-1:0] cnt_q,      cnt_d;
  logic [DWELL_W-1:0] dwell_q,    dwell_d;
  logic [NUM_CH-1:0]  mask_q,     mask_d;
`ifdef DEMUX_SEQ_LOOP_EN
  logic               stop_pend_q, stop_pend_d;
  next_ch_t           wrap_ch;
`endif

  logic [DWELL_W-1:0] dwell_eff;
  logic [NUM_CH-1:0]  srch_mask;
  logic [SEL_W-1:0]   srch_idx;
  logic               srch_from_start;
  logic               srch_found;
  logic [SEL_W-1:0]   srch_next;

  // A zero dwell would otherwise mean "never advance"; clamp it to one cycle.
  assign dwell_eff = (dwell == '0) ? DWELL_W'(1) : dwell;

  // One finder serves both the start path (live ch_mask, search from -1) and
  // the advance path (latched mask, search above the current select).
  demux_next_ch u_next_ch (
    .mask       (srch_mask),
    .cur_idx    (srch_idx),
    .from_start (srch_from_start),
    .found      (srch_found),
    .next_idx   (srch_next)
  );

`ifdef DEMUX_SEQ_LOOP_EN
  assign wrap_ch = next_set_bit(mask_q, sel_q, 1'b1);
`endif

  // Next-state and registered-output logic. Every output is computed for the
  // cycle after the edge so that sel_o/ch_valid/busy/done come straight from
  // flops; DONE outputs are therefore set on the transition into DONE.
  always_comb begin
    state_d         = state_q;
    sel_d           = sel_q;
    ch_valid_d      = ch_valid_q;
    busy_d          = busy_q;
    done_d          = 1'b0;
    cnt_d           = cnt_q;
    dwell_d         = dwell_q;
    mask_d          = mask_q;
    srch_mask       = mask_q;
    srch_idx        = sel_q;
    srch_from_start = 1'b0;
`ifdef DEMUX_SEQ_LOOP_EN
    stop_pend_d     = stop_pend_q | stop;
`endif

    case (state_q)
      IDLE: begin
        srch_mask       = ch_mask;
        srch_from_start = 1'b1;
`ifdef DEMUX_SEQ_LOOP_EN
        stop_pend_d     = 1'b0;
`endif
        if (start) begin
          dwell_d = dwell_eff;
          mask_d  = ch_mask;
          if (srch_found) begin
            state_d    = SCAN;
            sel_d      = srch_next;
            ch_valid_d = 1'b1;
            busy_d     = 1'b1;
            cnt_d      = dwell_eff;
          end else begin
            state_d    = DONE;
            sel_d      = '0;
            ch_valid_d = 1'b0;
            busy_d     = 1'b0;
            done_d     = 1'b1;
          end
        end
      end

      SCAN: begin
        if (cnt_q <= DWELL_W'(1)) begin
`ifdef DEMUX_SEQ_LOOP_EN
          if (stop_pend_q || stop) begin
            state_d    = DONE;
            sel_d      = '0;
            ch_valid_d = 1'b0;
            busy_d     = 1'b0;
            done_d     = 1'b1;
            cnt_d      = '0;
          end else if (srch_found) begin
            sel_d = srch_next;
            cnt_d = dwell_q;
          end else begin
            sel_d  = wrap_ch.idx;
            cnt_d  = dwell_q;
            done_d = 1'b1;
          end
`else
          if (srch_found) begin
            sel_d = srch_next;
            cnt_d = dwell_q;
          end else begin
            state_d    = DONE;
            sel_d      = '0;
            ch_valid_d = 1'b0;
            busy_d     = 1'b0;
            done_d     = 1'b1;
            cnt_d      = '0;
          end
`endif
        end else begin
          cnt_d = cnt_q - DWELL_W'(1);
        end
      end

      DONE: begin
        state_d    = IDLE;
        sel_d      = '0;
        ch_valid_d = 1'b0;
        busy_d     = 1'b0;
`ifdef DEMUX_SEQ_LOOP_EN
        stop_pend_d = 1'b0;
`endif
      end

      default: begin
        state_d    = IDLE;
        sel_d      = '0;
        ch_valid_d = 1'b0;
        busy_d     = 1'b0;
      end
    endcase
  end

  // State and output registers; reset wins over any pending start.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      sel_q      <= '0;
      ch_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      cnt_q      <= '0;
      dwell_q    <= '0;
      mask_q     <= '0;
`ifdef DEMUX_SEQ_LOOP_EN
      stop_pend_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      ch_valid_q <= ch_valid_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      cnt_q      <= cnt_d;
      dwell_q    <= dwell_d;
      mask_q     <= mask_d;
`ifdef DEMUX_SEQ_LOOP_EN
      stop_pend_q <= stop_pend_d;
`endif
    end
  end

  assign sel_o    = sel_q;
  assign ch_valid = ch_valid_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign dout     = din & ch_valid_q;

endmodule

// File: tb/tb_demux_sel_sequencer.sv
// -----------------------------------------------------------------------------
// tb_demux_sel_sequencer
// Directed bench for demux_sel_sequencer: reset, mid-sweep reset, full sweep,
// sparse mask with zero dwell, empty mask, data gating, ignored starts and
// (with DEMUX_SEQ_LOOP_EN) looping sweeps ended by stop.
// -----------------------------------------------------------------------------
module tb_demux_sel_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] dwell;
  logic [7:0] ch_mask;
  logic       din;
`ifdef DEMUX_SEQ_LOOP_EN
  logic       stop;
`endif
  logic [2:0] sel_o;
  logic       dout;
  logic       ch_valid;
  logic       busy;
  logic       done;

  int errors = 0;
  int checks = 0;

  demux_sel_sequencer #(.DWELL_W(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .dwell    (dwell),
    .ch_mask  (ch_mask),
    .din      (din),
`ifdef DEMUX_SEQ_LOOP_EN
    .stop     (stop),
`endif
    .sel_o    (sel_o),
    .dout     (dout),
    .ch_valid (ch_valid),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  // Advance one rising edge and settle just after it; inputs are changed and
  // outputs sampled at this point, well away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; din = 1'b1;
    tick();
    checks++; if (sel_o !== 3'd0)   begin errors++; $display("[TB] FAIL reset_sel got=%0d exp=0", sel_o); end
    checks++; if (ch_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid got=%b exp=0", ch_valid); end
    checks++; if (busy !== 1'b0)    begin errors++; $display("[TB] FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0)    begin errors++; $display("[TB] FAIL reset_done got=%b exp=0", done); end
    checks++; if (dout !== 1'b0)    begin errors++; $display("[TB] FAIL reset_dout got=%b exp=0", dout); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_sweep();
    ch_mask = 8'hFF; dwell = 8'd4; din = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (5) tick();
    checks++; if (sel_o !== 3'd1 || busy !== 1'b1) begin errors++; $display("[TB] FAIL midrst_pre got sel=%0d busy=%b exp sel=1 busy=1", sel_o, busy); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if ({sel_o, ch_valid, busy, done, dout} !== 7'b0) begin errors++; $display("[TB] FAIL midrst_outs got sel=%0d v=%b b=%b d=%b o=%b exp all 0", sel_o, ch_valid, busy, done, dout); end
    for (int c = 0; c < 4; c++) begin
      tick();
      checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("[TB] FAIL midrst_after%0d got done=%b busy=%b exp 0 0", c, done, busy); end
    end
  endtask

  task automatic test_full_sweep();
    logic [2:0] exp_sel;
    ch_mask = 8'hFF; dwell = 8'd2; din = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < 16; c++) begin
      exp_sel = 3'(c / 2);
      checks++;
      if (sel_o !== exp_sel || dout !== 1'b1 || busy !== 1'b1 || done !== 1'b0 || ch_valid !== 1'b1) begin
        errors++;
        $display("[TB] FAIL full_c%0d got sel=%0d o=%b b=%b d=%b v=%b exp sel=%0d o=1 b=1 d=0 v=1", c, sel_o, dout, busy, done, ch_valid, exp_sel);
      end
      tick();
    end
    checks++; if (done !== 1'b1 || busy !== 1'b0 || ch_valid !== 1'b0 || sel_o !== 3'd0) begin errors++; $display("[TB] FAIL full_done got d=%b b=%b v=%b sel=%0d exp d=1 b=0 v=0 sel=0", done, busy, ch_valid, sel_o); end
    tick();
    checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("[TB] FAIL full_idle got d=%b b=%b exp 0 0", done, busy); end
  endtask

  task automatic test_sparse_dwell0();
    logic [2:0] exp_sel [3];
    exp_sel[0] = 3'd2; exp_sel[1] = 3'd5; exp_sel[2] = 3'd7;
    ch_mask = 8'b1010_0100; dwell = 8'd0; start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < 3; c++) begin
      checks++; if (sel_o !== exp_sel[c] || ch_valid !== 1'b1 || done !== 1'b0) begin errors++; $display("[TB] FAIL sparse_c%0d got sel=%0d v=%b d=%b exp sel=%0d v=1 d=0", c, sel_o, ch_valid, done, exp_sel[c]); end
      tick();
    end
    checks++; if (done !== 1'b1 || busy !== 1'b0) begin errors++; $display("[TB] FAIL sparse_done got d=%b b=%b exp d=1 b=0", done, busy); end
    tick();
  endtask

  task automatic test_empty_mask();
    ch_mask = 8'h00; dwell = 8'd3; start = 1'b1;
    tick();
    start = 1'b0;
    checks++; if (done !== 1'b1 || busy !== 1'b0 || ch_valid !== 1'b0) begin errors++; $display("[TB] FAIL empty_done got d=%b b=%b v=%b exp d=1 b=0 v=0", done, busy, ch_valid); end
    tick();
    checks++; if (done !== 1'b0 || busy !== 1'b0 || ch_valid !== 1'b0) begin errors++; $display("[TB] FAIL empty_after got d=%b b=%b v=%b exp 0 0 0", done, busy, ch_valid); end
  endtask

  task automatic test_data_gating();
    din = 1'b1;
    #1;
    checks++; if (dout !== 1'b0) begin errors++; $display("[TB] FAIL gate_before got=%b exp=0", dout); end
    ch_mask = 8'b0000_0100; dwell = 8'd4; start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < 4; c++) begin
      din = c[0];
      #1;
      checks++; if (sel_o !== 3'd2 || dout !== din) begin errors++; $display("[TB] FAIL gate_c%0d got sel=%0d o=%b exp sel=2 o=%b", c, sel_o, dout, din); end
      tick();
    end
    din = 1'b1;
    #1;
    checks++; if (dout !== 1'b0 || done !== 1'b1) begin errors++; $display("[TB] FAIL gate_after got o=%b d=%b exp o=0 d=1", dout, done); end
    tick();
  endtask

  task automatic test_back_to_back();
    int ndone;
    logic [2:0] exp_sel;
    ndone = 0;
    ch_mask = 8'h03; dwell = 8'd2; start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < 4; c++) begin
      exp_sel = 3'(c / 2);
      checks++; if (sel_o !== exp_sel) begin errors++; $display("[TB] FAIL b2b_c%0d got sel=%0d exp=%0d", c, sel_o, exp_sel); end
      if (c == 1) begin start = 1'b1; ch_mask = 8'hF0; dwell = 8'd5; end
      tick();
      start = 1'b0;
    end
    checks++; if (done !== 1'b1) begin errors++; $display("[TB] FAIL b2b_done got=%b exp=1", done); end
    ndone = 1;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < 8; c++) begin
      if (done === 1'b1) ndone++;
      checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL b2b_idle%0d got busy=%b exp=0", c, busy); end
      tick();
    end
    checks++; if (ndone !== 1) begin errors++; $display("[TB] FAIL b2b_count got=%0d exp=1", ndone); end
  endtask

`ifdef DEMUX_SEQ_LOOP_EN
  task automatic test_loop();
    logic [2:0] exp_sel;
    logic       exp_done;
    stop = 1'b0;
    ch_mask = 8'h03; dwell = 8'd1; start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < 8; c++) begin
      exp_sel  = 3'(c % 2);
      exp_done = (c == 2 || c == 4 || c == 6);
      checks++; if (sel_o !== exp_sel || done !== exp_done || busy !== 1'b1 || ch_valid !== 1'b1) begin errors++; $display("[TB] FAIL loop_c%0d got sel=%0d d=%b b=%b v=%b exp sel=%0d d=%b b=1 v=1", c, sel_o, done, busy, ch_valid, exp_sel, exp_done); end
      if (c == 7) stop = 1'b1;
      tick();
      stop = 1'b0;
    end
    checks++; if (done !== 1'b1 || busy !== 1'b0 || ch_valid !== 1'b0) begin errors++; $display("[TB] FAIL loop_final got d=%b b=%b v=%b exp d=1 b=0 v=0", done, busy, ch_valid); end
    tick();
  endtask
`endif

  initial begin
    rst = 1'b1; start = 1'b0; dwell = 8'd0; ch_mask = 8'd0; din = 1'b0;
`ifdef DEMUX_SEQ_LOOP_EN
    stop = 1'b0;
`endif
    test_reset();
    test_reset_mid_sweep();
    test_full_sweep();
    test_sparse_dwell0();
    test_empty_mask();
    test_data_gating();
    test_back_to_back();
`ifdef DEMUX_SEQ_LOOP_EN
    test_loop();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
